// File: rtl/switch_out_arbiter.sv
// Per-output round-robin arbiter: grants one qualified input, captures its
// FIFO head word and forwards it on a valid/ready output.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   port_req[i]      input i requests (held until granted)
//   pkt_dst[4i+:4]   destination of input i's head packet
//   fifo_data[16i+:16] input i's FIFO head word {data,target,source}
//   out_ready        downstream accepts data_out
//   grant            registered one-hot grant (one-cycle pulse)
//   valid_out        data_out holds a packet
//   data_out         captured packet word
//   pkt_count        packets accepted downstream (wraps)
//   dst_err          sticky: captured target field != PORT_ID
module switch_out_arbiter #(
  parameter logic [3:0] PORT_ID   = 4'd0,
  parameter int         NUM_PORTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     port_req,
  input  logic [4*NUM_PORTS-1:0]   pkt_dst,
  input  logic [16*NUM_PORTS-1:0]  fifo_data,
  input  logic                     out_ready,
  output logic [NUM_PORTS-1:0]     grant,
  output logic                     valid_out,
  output logic [15:0]              data_out,
  output logic [15:0]              pkt_count,
  output logic                     dst_err
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   sel;

  logic [NUM_PORTS-1:0] qreq;
  logic                 any_req;
  logic [PW-1:0]        win;
  logic [15:0]          cap_word;
  logic [NUM_PORTS-1:0] win_oh;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      qreq[i] = port_req[i] &&
                (pkt_dst[4*i +: 4] == PORT_ID);
    end
  end

  // Search starts just after the last winner and wraps.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    any_req = 1'b0;
    win     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!any_req && qreq[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  assign win_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win;

  assign cap_word = fifo_data[16*int'(sel) +: 16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NUM_PORTS-1);
      sel       <= '0;
      grant     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      pkt_count <= '0;
      dst_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= win_oh;
            sel    <= win;
            rr_ptr <= win;
            state  <= GRANT;
          end else begin
            grant  <= '0;
          end
        end
        GRANT: begin
          // Head word is still pre-pop at this edge.
          data_out  <= cap_word;
          valid_out <= 1'b1;
          grant     <= '0;
          if (cap_word[7:4] != PORT_ID) begin
            dst_err <= 1'b1;
          end
          state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            pkt_count <= pkt_count + 16'd1;
            valid_out <= 1'b0;
            if (any_req) begin
              grant  <= win_oh;
              sel    <= win;
              rr_ptr <= win;
              state  <= GRANT;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          valid_out <= 1'b0;
          data_out  <= '0;
        end
      endcase
    end
  end

endmodule
